// File: rtl/fetch_unit.sv
// Instruction fetch front end: one outstanding memory request feeding a
// two-deep output/skid buffer, with redirect flush and wrap-around PC.
module fetch_unit #(
    parameter logic [63:0] RESET_PC = 64'd0,
    parameter logic [63:0] PC_STEP  = 64'd1
) (
    input  logic        clock,
    input  logic        reset_n,
    output logic [63:0] imem_addr,
    input  logic [63:0] imem_inst,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_target,
    output logic        out_valid,
    output logic [63:0] out_inst,
    output logic [63:0] out_pc
);

    logic [63:0] pc_q, pc_d;
    logic        inflight_q, inflight_d;
    logic [63:0] inflight_pc_q, inflight_pc_d;
    logic        out_valid_q, out_valid_d;
    logic [63:0] out_inst_q, out_inst_d;
    logic [63:0] out_pc_q, out_pc_d;
    logic        skid_valid_q, skid_valid_d;
    logic [63:0] skid_inst_q, skid_inst_d;
    logic [63:0] skid_pc_q, skid_pc_d;

    logic [1:0]  occupancy_s;
    logic        consume_s;
    logic        issue_s;

    // The in-flight request counts as occupied so a returning word always has a slot.
    assign occupancy_s = {1'b0, out_valid_q} + {1'b0, skid_valid_q} + {1'b0, inflight_q};
    assign consume_s   = out_valid_q & ~stall;
    assign issue_s     = ((occupancy_s - {1'b0, consume_s}) < 2'd2) & ~redirect_valid;

    assign imem_addr = pc_q;
    assign out_valid = out_valid_q;
    assign out_inst  = out_inst_q;
    assign out_pc    = out_pc_q;

    // Next-state: redirect flush, issue, drain of the output slot, capture of returning data.
    always_comb begin
        pc_d          = pc_q;
        inflight_d    = 1'b0;
        inflight_pc_d = inflight_pc_q;
        out_valid_d   = out_valid_q;
        out_inst_d    = out_inst_q;
        out_pc_d      = out_pc_q;
        skid_valid_d  = skid_valid_q;
        skid_inst_d   = skid_inst_q;
        skid_pc_d     = skid_pc_q;

        if (redirect_valid) begin
            pc_d         = redirect_target;
            inflight_d   = 1'b0;
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else begin
            if (issue_s) begin
                inflight_d    = 1'b1;
                inflight_pc_d = pc_q;
                pc_d          = pc_q + PC_STEP;
            end else begin
                inflight_d    = 1'b0;
            end

            if (consume_s) begin
                if (skid_valid_q) begin
                    out_valid_d  = 1'b1;
                    out_inst_d   = skid_inst_q;
                    out_pc_d     = skid_pc_q;
                    skid_valid_d = 1'b0;
                end else begin
                    out_valid_d  = 1'b0;
                end
            end else begin
                out_valid_d = out_valid_q;
            end

            // After draining, an empty output slot takes the returning word; otherwise the skid does.
            if (inflight_q) begin
                if (!out_valid_d) begin
                    out_valid_d = 1'b1;
                    out_inst_d  = imem_inst;
                    out_pc_d    = inflight_pc_q;
                end else begin
                    skid_valid_d = 1'b1;
                    skid_inst_d  = imem_inst;
                    skid_pc_d    = inflight_pc_q;
                end
            end else begin
                skid_valid_d = skid_valid_d;
            end
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pc_q          <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= 64'd0;
            out_valid_q   <= 1'b0;
            out_inst_q    <= 64'd0;
            out_pc_q      <= 64'd0;
            skid_valid_q  <= 1'b0;
            skid_inst_q   <= 64'd0;
            skid_pc_q     <= 64'd0;
        end else begin
            pc_q          <= pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            out_valid_q   <= out_valid_d;
            out_inst_q    <= out_inst_d;
            out_pc_q      <= out_pc_d;
            skid_valid_q  <= skid_valid_d;
            skid_inst_q   <= skid_inst_d;
            skid_pc_q     <= skid_pc_d;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a randomized
// stall/redirect run scored against an in-order delivery model.
module tb_fetch_unit;

    logic        clock;
    logic        reset_n;
    logic [63:0] imem_addr;
    logic [63:0] imem_inst;
    logic        stall;
    logic        redirect_valid;
    logic [63:0] redirect_target;
    logic        out_valid;
    logic [63:0] out_inst;
    logic [63:0] out_pc;

    logic [63:0] mem_q;
    logic [63:0] exp_pc;
    int          since_flush;
    int          delivered;
    int          n_checks;
    int          n_errors;

    fetch_unit #(.RESET_PC(64'd0), .PC_STEP(64'd1)) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .imem_addr       (imem_addr),
        .imem_inst       (imem_inst),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .out_valid       (out_valid),
        .out_inst        (out_inst),
        .out_pc          (out_pc)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Memory holds Mem[k] = k + 100 and answers one cycle after sampling the address.
    always @(posedge clock) mem_q <= imem_addr + 64'd100;
    assign imem_inst = mem_q;

    task automatic check64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One cycle: drive inputs at the falling edge, score delivery, step across the rising edge.
    task automatic tick(input logic s, input logic r, input logic [63:0] t);
        logic        hold;
        logic [63:0] hold_pc;
        logic [63:0] hold_inst;
        logic [63:0] outstanding;
        stall           = s;
        redirect_valid  = r;
        redirect_target = t;
        hold            = 1'b0;
        hold_pc         = 64'd0;
        hold_inst       = 64'd0;
        #1;
        if (since_flush >= 2) check64("no_bubble", {63'd0, out_valid}, 64'd1);
        if (r) begin
            exp_pc      = t;
            since_flush = 0;
        end else begin
            if (out_valid && !s) begin
                check64("seq_pc", out_pc, exp_pc);
                check64("seq_inst", out_inst, exp_pc + 64'd100);
                exp_pc = exp_pc + 64'd1;
                delivered++;
            end
            if (out_valid && s) begin
                hold      = 1'b1;
                hold_pc   = out_pc;
                hold_inst = out_inst;
            end
            since_flush++;
        end
        @(posedge clock);
        #1;
        if (hold) begin
            check64("hold_pc", out_pc, hold_pc);
            check64("hold_inst", out_inst, hold_inst);
        end
        outstanding = imem_addr - exp_pc;
        check64("occ_le2", {63'd0, (outstanding > 64'd2)}, 64'd0);
        @(negedge clock);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks        = 0;
        n_errors        = 0;
        delivered       = 0;
        since_flush     = 0;
        exp_pc          = 64'd0;
        reset_n         = 1'b0;
        stall           = 1'b0;
        redirect_valid  = 1'b0;
        redirect_target = 64'd0;

        repeat (2) @(negedge clock);
        check64("rst_valid", {63'd0, out_valid}, 64'd0);
        check64("rst_pc", out_pc, 64'd0);
        check64("rst_inst", out_inst, 64'd0);
        check64("rst_addr", imem_addr, 64'd0);
        reset_n = 1'b1;

        // Startup latency and back-to-back streaming.
        tick(1'b0, 1'b0, 64'd0);
        check64("first_valid", {63'd0, out_valid}, 64'd0);
        check64("first_addr", imem_addr, 64'd1);
        for (int k = 0; k < 3; k++) begin
            tick(1'b0, 1'b0, 64'd0);
            check64("stream_pc", out_pc, 64'(k));
            check64("stream_inst", out_inst, 64'(k) + 64'd100);
        end

        // Three stalled cycles holding entry 2.
        for (int k = 0; k < 3; k++) begin
            tick(1'b1, 1'b0, 64'd0);
            check64("stall_pc", out_pc, 64'd2);
            check64("stall_inst", out_inst, 64'd102);
            check64("stall_addr", imem_addr, 64'd4);
        end
        for (int k = 3; k < 6; k++) begin
            tick(1'b0, 1'b0, 64'd0);
            check64("release_pc", out_pc, 64'(k));
            check64("release_valid", {63'd0, out_valid}, 64'd1);
        end

        // Redirect under stall with both buffers full.
        tick(1'b1, 1'b0, 64'd0);
        tick(1'b1, 1'b1, 64'd40);
        check64("redir_valid", {63'd0, out_valid}, 64'd0);
        check64("redir_addr", imem_addr, 64'd40);
        tick(1'b0, 1'b0, 64'd0);
        check64("redir_gap", {63'd0, out_valid}, 64'd0);
        tick(1'b0, 1'b0, 64'd0);
        check64("redir_pc", out_pc, 64'd40);
        check64("redir_inst", out_inst, 64'd140);

        // PC wrap-around.
        tick(1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
        tick(1'b0, 1'b0, 64'd0);
        tick(1'b0, 1'b0, 64'd0);
        check64("wrap_pc_hi", out_pc, 64'hFFFF_FFFF_FFFF_FFFF);
        check64("wrap_inst_hi", out_inst, 64'd99);
        tick(1'b0, 1'b0, 64'd0);
        check64("wrap_pc_lo", out_pc, 64'd0);
        check64("wrap_inst_lo", out_inst, 64'd100);

        // Asynchronous reset pulse between edges while streaming.
        #2;
        reset_n = 1'b0;
        #1;
        check64("arst_valid", {63'd0, out_valid}, 64'd0);
        check64("arst_addr", imem_addr, 64'd0);
        check64("arst_pc", out_pc, 64'd0);
        #1;
        reset_n     = 1'b1;
        exp_pc      = 64'd0;
        since_flush = 0;
        @(posedge clock);
        #1;
        check64("arst_edge1_valid", {63'd0, out_valid}, 64'd0);
        check64("arst_edge1_addr", imem_addr, 64'd1);
        @(negedge clock);
        since_flush = 1;
        tick(1'b0, 1'b0, 64'd0);
        check64("arst_edge2_pc", out_pc, 64'd0);
        check64("arst_edge2_valid", {63'd0, out_valid}, 64'd1);

        // Random stall and occasional redirect, scored by the in-order model.
        delivered = 0;
        for (int i = 0; i < 1000; i++) begin
            logic        rs;
            logic        rr;
            logic [63:0] rt;
            rs = 1'($urandom_range(1, 0));
            rr = ($urandom_range(63, 0) == 0);
            rt = {32'($urandom), 32'($urandom)};
            if ($urandom_range(1, 0) == 0) rt = 64'hFFFF_FFFF_FFFF_FFFF - 64'($urandom_range(3, 0));
            tick(rs, rr, rt);
        end
        repeat (4) tick(1'b0, 1'b0, 64'd0);
        check64("delivered_min", {63'd0, (delivered > 200)}, 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
